// File: rtl/sub64_pkg.sv
// Shared types and helpers for the sequential half-width subtractor.
package sub64_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOW  = 2'b01,
    HIGH = 2'b10,
    DONE = 2'b11
  } sub_state_t;

  // Signed overflow of a - b: operand signs differ and the result sign
  // disagrees with the minuend sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_half.sv
// Combinational M-bit subtractor with borrow in/out, shared by both halves.
module sub_half #(
  parameter int M = 32
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         bin,
  output logic [M-1:0] d,
  output logic         bout
);

  logic [M:0] full;

  // One extra bit on the left captures the borrow-out of the half operation.
  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {{M{1'b0}}, bin};
    d    = full[M-1:0];
    bout = full[M];
  end

endmodule

// File: rtl/subtractor_64bit_seq.sv
// Multi-cycle N-bit subtractor: low half first, then high half with the
// borrow chained through a register, using one shared half-width datapath.
module subtractor_64bit_seq
  import sub64_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         ovf,
  output logic         zero
);

  localparam int M = N / 2;

  sub_state_t   state_q, state_d;
  logic [N-1:0] a_q, b_q;
  logic [M-1:0] lo_q;
  logic         bw_q;

  logic [M-1:0] x_h, y_h, d_h;
  logic         bin_h, bout_h;

  // Steer the shared half datapath: high halves plus chained borrow in HIGH,
  // low halves with no borrow-in otherwise.
  always_comb begin
    x_h   = a_q[M-1:0];
    y_h   = b_q[M-1:0];
    bin_h = 1'b0;
    if (state_q == HIGH) begin
      x_h   = a_q[N-1:M];
      y_h   = b_q[N-1:M];
      bin_h = bw_q;
    end
  end

  sub_half #(.M(M)) u_half (
    .a   (x_h),
    .b   (y_h),
    .bin (bin_h),
    .d   (d_h),
    .bout(bout_h)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == IDLE);
    case (state_q)
      IDLE:    if (in_valid) state_d = LOW;
      LOW:     state_d = HIGH;
      HIGH:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand capture, half results and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      lo_q      <= '0;
      bw_q      <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q <= op_a;
            b_q <= op_b;
          end
        end
        LOW: begin
          lo_q <= d_h;
          bw_q <= bout_h;
        end
        HIGH: begin
          diff      <= {d_h, lo_q};
          borrow    <= bout_h;
          ovf       <= sub_ovf(a_q[N-1], b_q[N-1], d_h[M-1]);
          zero      <= ({d_h, lo_q} == '0);
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_64bit_seq.sv
// Directed self-checking bench for subtractor_64bit_seq.
module tb_subtractor_64bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        borrow, ovf, zero;

  int n_cmp = 0;
  int n_err = 0;

  subtractor_64bit_seq #(.N(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string tag, input logic [63:0] ed,
                            input logic eb, input logic eo, input logic ez);
    chk({tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, ".diff"},      diff, ed);
    chk({tag, ".borrow"},    {63'd0, borrow}, {63'd0, eb});
    chk({tag, ".ovf"},       {63'd0, ovf},    {63'd0, eo});
    chk({tag, ".zero"},      {63'd0, zero},   {63'd0, ez});
  endtask

  // Full transaction with out_ready held high; checks timing and result.
  task automatic do_sub(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ed, input logic eb, input logic eo,
                        input logic ez);
    chk({tag, ".in_ready_idle"}, {63'd0, in_ready}, 64'd1);
    op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b1;
    step();                                   // accept edge, now LOW
    in_valid = 1'b0; op_a = ~a; op_b = a;     // operands may change freely
    chk({tag, ".in_ready_low"}, {63'd0, in_ready}, 64'd0);
    chk({tag, ".ov_low"}, {63'd0, out_valid}, 64'd0);
    step();                                   // HIGH
    chk({tag, ".ov_high"}, {63'd0, out_valid}, 64'd0);
    step();                                   // DONE, result registered
    chk_result(tag, ed, eb, eo, ez);
    step();                                   // handshake done, back to IDLE
    chk({tag, ".ov_drop"}, {63'd0, out_valid}, 64'd0);
    chk({tag, ".in_ready_back"}, {63'd0, in_ready}, 64'd1);
    chk({tag, ".diff_hold"}, diff, ed);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst.in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.diff",      diff, 64'd0);
    chk("rst.flags",     {61'd0, borrow, ovf, zero}, 64'd0);

    do_sub("t1", 64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0);
    do_sub("t2a", 64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_sub("t2b", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_sub("t3a", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    do_sub("t3b", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    do_sub("t4", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b0, 1'b1);
    do_sub("t4b", 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0001,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

    // Backpressure: 100 - 30 held in DONE while a second pair is offered.
    out_ready = 1'b0;
    op_a = 64'd100; op_b = 64'd30; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk_result("bp.first", 64'd70, 1'b0, 1'b0, 1'b0);
    op_a = 64'h10; op_b = 64'h20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp.hold_diff",  diff, 64'd70);
      chk("bp.hold_flags", {61'd0, borrow, ovf, zero}, 64'd0);
      chk("bp.in_ready",   {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    step();                                   // handshake, back to IDLE
    chk("bp.drop",     {63'd0, out_valid}, 64'd0);
    chk("bp.idle",     {63'd0, in_ready},  64'd1);
    step();                                   // second pair accepted
    in_valid = 1'b0;
    chk("bp.accept2", {63'd0, in_ready}, 64'd0);
    step();
    step();
    chk_result("bp.second", 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0);
    step();

    // Reset while in HIGH abandons the operation.
    op_a = 64'd9; op_b = 64'd4; in_valid = 1'b1;
    step();                                   // LOW
    in_valid = 1'b0;
    step();                                   // HIGH
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rmid.diff",      diff, 64'd0);
    chk("rmid.flags",     {61'd0, borrow, ovf, zero}, 64'd0);
    chk("rmid.in_ready",  {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rmid.no_pulse", {63'd0, out_valid}, 64'd0);
    end

    // Reset together with in_valid: operands are not captured.
    op_a = 64'd7; op_b = 64'd1; in_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rv.in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("rv.still_idle", {63'd0, in_ready}, 64'd1);
    step();
    step();
    chk("rv.no_result", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/subtractor_64bit_seq.md
Name: subtractor_64bit_seq

Overview:
Multi-cycle signed/unsigned N-bit subtractor computing diff = op_a - op_b. It uses a single N/2-bit half-width datapath, processing the low half first and then the high half with the borrow chained between them.
- Valid/ready handshake on input and output.
- Produces borrow (unsigned underflow), signed overflow and zero flags.
- Serves as the difference-side counterpart of the sequential adder in the arithmetic block set.

Parameters:
N, 64, operand/result width; must be even and >= 4
M, N/2 (localparam, not overridable), half-datapath width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands (high only in IDLE)
op_a  input  N  minuend, signed two's complement
op_b  input  N  subtrahend, signed two's complement
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
diff  output  N  op_a - op_b, modulo 2^N
borrow  output  1  1 when op_a < op_b as unsigned
ovf  output  1  signed overflow
zero  output  1  diff == 0

Behaviour:
- All state and outputs registered; rst sampled only on rising clk.
- Reset values: state=IDLE, out_valid=0, diff=0, borrow=0, ovf=0, zero=0, internal operand/borrow regs=0.
- in_ready = (state==IDLE), combinational from state. in_ready is 0 during rst assertion cycle's following state only if not IDLE (it is IDLE after reset).
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: on in_valid && in_ready, capture op_a/op_b into a_q/b_q and go to LOW. Otherwise stay.
  - LOW: lo_q <= a_q[M-1:0] - b_q[M-1:0]; bw_q <= low borrow-out; go to HIGH.
  - HIGH: compute a_q[N-1:M] - b_q[N-1:M] - bw_q. Register:
    - diff <= {hi, lo_q}
    - borrow <= high borrow-out
    - ovf <= (a_q[N-1] != b_q[N-1]) && (hi[M-1] != a_q[N-1])
    - zero <= ({hi, lo_q} == 0)
    - out_valid <= 1
    - go to DONE.
  - DONE: hold out_valid=1 and all result outputs stable until out_ready. On out_ready, out_valid <= 0 and go to IDLE.
- Latency: out_valid rises 3 clocks after the accepting edge (accept edge -> LOW -> HIGH -> DONE). Minimum initiation interval is 4 cycles, since no new operands are accepted until the result handshake completes.
- in_valid while busy (LOW/HIGH/DONE) is ignored; op_a/op_b may change freely after acceptance without affecting the result.
- After the output handshake, diff/borrow/ovf/zero keep their last values (out_valid=0) until the next HIGH cycle overwrites them.
- Half-width arithmetic: every half operation is M+1 bits wide, {borrow_out, d} = {1'b0, x} - {1'b0, y} - bin. Borrow-out is the inverted carry of x + ~y + ~bin.
- Reset mid-operation (any state): the operation is abandoned, all registers return to reset values next edge, and no out_valid pulse is emitted.
- Simultaneous rst and in_valid: rst wins and the operands are not captured.
- Wrap-around: results are modulo 2^N. Flags carry the range information; no saturation.

Decomposition:
- Package sub64_pkg: typedef enum logic [1:0] {IDLE=2'b00, LOW=2'b01, HIGH=2'b10, DONE=2'b11} sub_state_t.
- One sub-module sub_half #(M): combinational M-bit subtractor. Ports a, b, bin, d, bout. Instantiated once and muxed between low/high halves by state.
- Top holds the FSM, operand/result registers, the flag logic and the handshake.

Test Plan:
1. op_a=5, op_b=3, out_ready=1 -> diff=2, borrow=0, ovf=0, zero=0. out_valid is high exactly 3 clocks after the accept edge, for 1 cycle; in_ready returns high the cycle after.
2. op_a=0x0000_0001_0000_0000, op_b=1 -> diff=0x0000_0000_FFFF_FFFF, borrow=0, ovf=0. This checks low-to-high borrow propagation. Also 0 - 1 -> diff=0xFFFF_FFFF_FFFF_FFFF, borrow=1, ovf=0.
3. Signed overflow:
   - 0x8000_0000_0000_0000 - 1 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, borrow=0.
   - 0x7FFF_FFFF_FFFF_FFFF - 0xFFFF_FFFF_FFFF_FFFF -> diff=0x8000_0000_0000_0000, ovf=1, borrow=1.
4. Equal operands 0x1234_5678_9ABC_DEF0 - same -> diff=0, zero=1, borrow=0, ovf=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, diff/flags stable, in_ready=0. A second in_valid with new operands is not captured. Raising out_ready drops out_valid next edge, after which the second pair is accepted.
6. Reset mid-op: assert rst for 1 cycle while in HIGH -> next edge state=IDLE, out_valid=0, diff=0, all flags 0, in_ready=1. No result pulse appears afterwards.
